// File: rtl/sipo_rx_if.sv
// rtl/sipo_rx_if.sv - serial input and parallel output handshake bundle for sipo_rx
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_en;
    logic             frame_start;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             overrun;
    logic             clr_ovr;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output sin, sin_en, frame_start, pout_ready, clr_ovr,
        input  pout, pout_valid, overrun, bit_cnt
    );

    modport slave (
        input  sin, sin_en, frame_start, pout_ready, clr_ovr,
        output pout, pout_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in/parallel-out receiver with valid/ready holding register and sticky overrun
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sipo_rx_if.slave   bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, base, shifted;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             done;

    always_comb begin
        // frame_start wipes the partial word before this cycle's sample lands
        base     = bus.frame_start ? '0 : shreg_q;
        cnt_base = bus.frame_start ? '0 : cnt_q;
        if (MSB_FIRST) shifted = {base[WIDTH-2:0], bus.sin};
        else           shifted = {bus.sin, base[WIDTH-1:1]};

        done = bus.sin_en && !bus.frame_start && (state_q == RECV) && (cnt_q == LAST);

        shreg_d = base;
        cnt_d   = cnt_base;
        if (bus.sin_en) begin
            shreg_d = done ? '0 : shifted;
            cnt_d   = done ? '0 : cnt_base + 1'b1;
        end
        state_d = (cnt_d != '0) ? RECV : IDLE;

        pout_d  = pout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q && !bus.clr_ovr;
        if (done) begin
            // a word that cannot be delivered is dropped; the held word survives
            if (valid_q && !bus.pout_ready) begin
                ovr_d = 1'b1;
            end else begin
                pout_d  = shifted;
                valid_d = 1'b1;
            end
        end else if (valid_q && bus.pout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - vector table and word scoreboard bench for sipo_rx
module tb_sipo_rx;
    logic clk;
    logic rst;

    sipo_rx_if #(.WIDTH(4)) a ();
    sipo_rx_if #(.WIDTH(4)) b ();

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a));
    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b));

    typedef struct {
        logic       sin, en, fs, rdy, clr;
        logic       ev;
        logic [3:0] ep;
        logic       eo;
        logic [2:0] ec;
        logic       push;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sin, en, fs, rdy, clr, ev, input logic [3:0] ep,
                       input logic eo, input logic [2:0] ec, input logic push);
        vec_t v;
        v.sin = sin; v.en = en; v.fs = fs; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ep = ep; v.eo = eo; v.ec = ec; v.push = push;
        vecs.push_back(v);
    endtask

    task automatic drive_a(input logic sin, en, fs, rdy, clr);
        a.sin = sin; a.sin_en = en; a.frame_start = fs; a.pout_ready = rdy; a.clr_ovr = clr;
        @(posedge clk);
        #1;
    endtask

    // Handshakes are observed at the falling edge, where inputs and outputs are both settled
    always @(negedge clk) begin
        if (!rst && a.pout_valid && a.pout_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_word", a.pout, 4'hx);
            else                chk("sb_word", a.pout, sb.pop_front());
        end
    end

    initial begin
        a.sin = 0; a.sin_en = 0; a.frame_start = 0; a.pout_ready = 0; a.clr_ovr = 0;
        b.sin = 0; b.sin_en = 0; b.frame_start = 0; b.pout_ready = 0; b.clr_ovr = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_valid", a.pout_valid, 1'b0);
        chk("reset_pout", a.pout, 4'h0);
        chk("reset_ovr", a.overrun, 1'b0);
        chk("reset_cnt", a.bit_cnt, 3'd0);

        // basic word 1010, then one-cycle accept
        add(1,1,0,0,0, 0,4'h0,0,1,0);
        add(0,1,0,0,0, 0,4'h0,0,2,0);
        add(1,1,0,0,0, 0,4'h0,0,3,0);
        add(0,1,0,0,0, 1,4'ha,0,0,1);
        add(0,0,0,1,0, 0,4'ha,0,0,0);
        // streaming 1010 0101 with ready held high
        add(1,1,0,1,0, 0,4'ha,0,1,0);
        add(0,1,0,1,0, 0,4'ha,0,2,0);
        add(1,1,0,1,0, 0,4'ha,0,3,0);
        add(0,1,0,1,0, 1,4'ha,0,0,1);
        add(0,1,0,1,0, 0,4'ha,0,1,0);
        add(1,1,0,1,0, 0,4'ha,0,2,0);
        add(0,1,0,1,0, 0,4'ha,0,3,0);
        add(1,1,0,1,0, 1,4'h5,0,0,1);
        // completion on the same edge as accept of the held word
        add(1,1,0,0,0, 1,4'h5,0,1,0);
        add(1,1,0,0,0, 1,4'h5,0,2,0);
        add(0,1,0,0,0, 1,4'h5,0,3,0);
        add(0,1,0,1,0, 1,4'hc,0,0,1);
        add(0,0,0,1,0, 0,4'hc,0,0,0);
        // overrun, clear, then set-wins-over-clear
        add(1,1,0,0,0, 0,4'hc,0,1,0);
        add(0,1,0,0,0, 0,4'hc,0,2,0);
        add(1,1,0,0,0, 0,4'hc,0,3,0);
        add(0,1,0,0,0, 1,4'ha,0,0,1);
        add(1,1,0,0,0, 1,4'ha,0,1,0);
        add(1,1,0,0,0, 1,4'ha,0,2,0);
        add(0,1,0,0,0, 1,4'ha,0,3,0);
        add(0,1,0,0,0, 1,4'ha,1,0,0);
        add(0,0,0,0,1, 1,4'ha,0,0,0);
        add(1,1,0,0,0, 1,4'ha,0,1,0);
        add(1,1,0,0,0, 1,4'ha,0,2,0);
        add(1,1,0,0,0, 1,4'ha,0,3,0);
        add(1,1,0,0,1, 1,4'ha,1,0,0);
        add(0,0,0,0,1, 1,4'ha,0,0,0);
        add(0,0,0,1,0, 0,4'ha,0,0,0);
        // frame_start restart and sin_en gaps -> 0101
        add(1,1,0,0,0, 0,4'ha,0,1,0);
        add(1,1,0,0,0, 0,4'ha,0,2,0);
        add(0,1,1,0,0, 0,4'ha,0,1,0);
        add(1,0,0,0,0, 0,4'ha,0,1,0);
        add(1,0,0,0,0, 0,4'ha,0,1,0);
        add(1,1,0,0,0, 0,4'ha,0,2,0);
        add(1,0,0,0,0, 0,4'ha,0,2,0);
        add(1,0,0,0,0, 0,4'ha,0,2,0);
        add(0,1,0,0,0, 0,4'ha,0,3,0);
        add(0,0,0,0,0, 0,4'ha,0,3,0);
        add(0,0,0,0,0, 0,4'ha,0,3,0);
        add(1,1,0,0,0, 1,4'h5,0,0,1);
        add(0,0,0,1,0, 0,4'h5,0,0,0);
        // frame_start on what would be the 4th bit, then frame_start alone
        add(1,1,0,0,0, 0,4'h5,0,1,0);
        add(1,1,0,0,0, 0,4'h5,0,2,0);
        add(1,1,0,0,0, 0,4'h5,0,3,0);
        add(1,1,1,0,0, 0,4'h5,0,1,0);
        add(0,0,1,0,0, 0,4'h5,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) sb.push_back(vecs[i].ep);
            drive_a(vecs[i].sin, vecs[i].en, vecs[i].fs, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d_valid", i), a.pout_valid, vecs[i].ev);
            chk($sformatf("v%0d_pout", i), a.pout, vecs[i].ep);
            chk($sformatf("v%0d_ovr", i), a.overrun, vecs[i].eo);
            chk($sformatf("v%0d_cnt", i), a.bit_cnt, vecs[i].ec);
        end

        // asynchronous reset while a word is held and another is partial
        drive_a(1,1,0,0,0); drive_a(0,1,0,0,0); drive_a(1,1,0,0,0); drive_a(0,1,0,0,0);
        chk("pre_rst_valid", a.pout_valid, 1'b1);
        drive_a(1,1,0,0,0); drive_a(1,1,0,0,0);
        chk("pre_rst_cnt", a.bit_cnt, 3'd2);
        a.sin = 0; a.sin_en = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", a.pout_valid, 1'b0);
        chk("async_rst_pout", a.pout, 4'h0);
        chk("async_rst_cnt", a.bit_cnt, 3'd0);
        chk("async_rst_ovr", a.overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive_a(0,1,0,0,0); drive_a(0,1,0,0,0); drive_a(1,1,0,0,0);
        sb.push_back(4'h3);
        drive_a(1,1,0,0,0);
        chk("post_rst_pout", a.pout, 4'h3);
        chk("post_rst_valid", a.pout_valid, 1'b1);
        drive_a(0,0,0,1,0);
        chk("post_rst_accept", a.pout_valid, 1'b0);

        // LSB-first instance: 1,0,0,0 -> 0001
        for (int i = 0; i < 4; i++) begin
            b.sin = (i == 0); b.sin_en = 1'b1;
            @(posedge clk);
            #1;
        end
        b.sin_en = 1'b0;
        chk("lsb_pout", b.pout, 4'h1);
        chk("lsb_valid", b.pout_valid, 1'b1);
        chk("lsb_cnt", b.bit_cnt, 3'd0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
